stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch digit counter.
- Debounces the pause and clear buttons and the adjust/select switches, and runs the IDLE/RUN/PAUSE/ADJUST mode FSM.
- Generates single-cycle advance/increment/clear strobes on the system clock, so the counter runs entirely in the clk domain with no derived clocks.
- Also drives the display blink enable for adjust mode.

Parameters:
- CLK_HZ, 100000000, clk frequency. Run tick period = CLK_HZ cycles; adjust tick period = CLK_HZ/2 cycles. Must be even and ≥4.
- DB_CYCLES, 1000000, consecutive cycles a synchronized input must differ from its debounced level before the level flips. Must be ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- btn_pause  in  1  raw pause/resume button, active-high, asynchronous
- btn_clear  in  1  raw clear button, active-high, asynchronous
- sw_adj  in  1  raw adjust-mode switch
- sw_sel  in  1  raw field select: 1 = seconds, 0 = minutes
- run_tick  out  1  one-cycle pulse: counter advances one second
- inc_sec  out  1  one-cycle pulse: adjust seconds field +1
- inc_min  out  1  one-cycle pulse: adjust minutes field +1
- cnt_clr  out  1  one-cycle pulse: counter clears to 00:00
- mode  out  2  current state: 00 IDLE, 01 RUN, 10 PAUSE, 11 ADJUST
- blink_on  out  1  display enable for the selected field

Behaviour:
- Reset (rst=0, async): mode=IDLE, all pulses 0, blink_on=1, all prescalers 0, all debounced levels 0, synchronizers 0.
- Input conditioning, identical for all four inputs:
  - 2-flop synchronizer.
  - Debounce counter increments while sync output != debounced level and clears otherwise.
  - When the counter equals DB_CYCLES-1 with the mismatch still present, the level flips on the next edge and the counter clears.
  - Press pulse for buttons = level & ~level_q (registered).
  - A raw change is acted on in the FSM exactly DB_CYCLES+3 cycles after its first sampled edge.
- FSM, all transitions registered. Priority order:
  1. Clear press: cnt_clr=1 for one cycle; next state = ADJUST if debounced adj=1, else IDLE. Run prescaler cleared. Any pause press or tick in the same cycle is dropped.
  2. adj level=1 and state!=ADJUST: go to ADJUST. Adjust prescaler cleared on entry.
  3. adj level=0 in ADJUST: go to PAUSE (time preserved).
  4. Pause press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. Ignored in ADJUST.
- Run prescaler:
  - Counts 0..CLK_HZ-1 only in RUN. Holds its value in PAUSE, so a resume continues the partial second.
  - Cleared by clear and in IDLE.
  - run_tick=1 on the cycle the count wraps CLK_HZ-1 -> 0.
  - A wrap coinciding with a pause press in RUN still emits run_tick, and the state then becomes PAUSE.
- Adjust prescaler:
  - Counts 0..CLK_HZ/2-1 only in ADJUST and wraps there.
  - On wrap: inc_sec=1 if debounced sel=1, else inc_min=1.
  - Exactly one of inc_sec/inc_min per wrap; never both; never outside ADJUST.
  - A sel change mid-period takes effect at the next wrap. The prescaler is not reset by a sel change.
- blink_on:
  - In ADJUST: 1 while adjust prescaler < CLK_HZ/4, else 0.
  - Outside ADJUST: constant 1.
- Output invariant: at most one of run_tick, inc_sec, inc_min, cnt_clr is high in any cycle. All four are registered outputs with no combinational path from inputs.

Test Plan (CLK_HZ=8, DB_CYCLES=4):
- Reset then 20 idle cycles -> mode=00, no pulses, blink_on=1. Assert rst=0 mid-RUN -> mode=00 immediately (async), no further run_tick.
- Press btn_pause (hold 10 cycles) -> mode=01 at raw-edge+7. run_tick every 8 cycles, first at 8 cycles after entering RUN. Press again -> mode=10, no ticks.
- Pause at prescaler=5, wait 30 cycles, resume -> first run_tick exactly 3 cycles after RUN re-entry.
- Raise sw_adj with sw_sel=0 -> mode=11, inc_min every 4 cycles, blink_on 1,1,0,0 pattern. Set sw_sel=1 -> pulses switch to inc_sec at the next wrap. Drop sw_adj -> mode=10.
- Clear and pause pressed in the same raw cycle during RUN -> single cnt_clr pulse, mode=00, no run_tick after. Same with sw_adj=1 -> mode=11.
- Bounce: toggle btn_pause every 2 cycles for 20 cycles, then release -> no press pulse, mode unchanged.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button/switch inputs and strobe/status outputs of the stopwatch controller.
// The master side drives raw inputs; the slave side is the controller.
interface stopwatch_ctrl_if;
  logic       btn_pause;
  logic       btn_clear;
  logic       sw_adj;
  logic       sw_sel;
  logic       run_tick;
  logic       inc_sec;
  logic       inc_min;
  logic       cnt_clr;
  logic [1:0] mode;
  logic       blink_on;

  modport master (
    output btn_pause,
    output btn_clear,
    output sw_adj,
    output sw_sel,
    input  run_tick,
    input  inc_sec,
    input  inc_min,
    input  cnt_clr,
    input  mode,
    input  blink_on
  );

  modport slave (
    input  btn_pause,
    input  btn_clear,
    input  sw_adj,
    input  sw_sel,
    output run_tick,
    output inc_sec,
    output inc_min,
    output cnt_clr,
    output mode,
    output blink_on
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: input debounce, IDLE/RUN/PAUSE/ADJUST FSM and
// single-cycle counter strobes, all in the clk domain.
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 100000000,
  parameter int DB_CYCLES = 1000000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_ADJ   = 2'b11;

  localparam int DW = $clog2(DB_CYCLES);
  localparam int RW = $clog2(CLK_HZ);
  localparam int AW = $clog2(CLK_HZ / 2);

  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ADJ_LAST = AW'(CLK_HZ / 2 - 1);
  localparam logic [AW-1:0] ADJ_HALF = AW'(CLK_HZ / 4);

  // bit order: 0 pause, 1 clear, 2 adj, 3 sel
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    lvl;
  logic [3:0]    lvl_q;
  logic [DW-1:0] db_cnt [4];

  assign raw = {bus.sw_sel, bus.sw_adj,
                bus.btn_clear, bus.btn_pause};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= ~lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Switch levels are taken from lvl_q so they line up
  // with the registered button press pulses.
  logic pause_p;
  logic clear_p;
  logic adj_d;
  logic sel_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_p <= 1'b0;
      clear_p <= 1'b0;
    end else begin
      pause_p <= lvl[0] & ~lvl_q[0];
      clear_p <= lvl[1] & ~lvl_q[1];
    end
  end

  assign adj_d = lvl_q[2];
  assign sel_d = lvl_q[3];

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [RW-1:0] rcnt;
  logic [AW-1:0] acnt;
  logic          run_wrap;
  logic          adj_wrap;

  always_comb begin
    nxt = state;
    if (clear_p) begin
      nxt = adj_d ? S_ADJ : S_IDLE;
    end else if (adj_d && state != S_ADJ) begin
      nxt = S_ADJ;
    end else if (!adj_d && state == S_ADJ) begin
      nxt = S_PAUSE;
    end else if (pause_p) begin
      unique case (state)
        S_IDLE:  nxt = S_RUN;
        S_RUN:   nxt = S_PAUSE;
        S_PAUSE: nxt = S_RUN;
        default: nxt = state;
      endcase
    end
  end

  assign run_wrap = (state == S_RUN) && (rcnt == RUN_LAST);
  assign adj_wrap = (state == S_ADJ) && (acnt == ADJ_LAST);

  logic run_pulse;
  logic sec_pulse;
  logic min_pulse;
  logic clr_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rcnt      <= '0;
      acnt      <= '0;
      run_pulse <= 1'b0;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      state     <= nxt;
      clr_pulse <= clear_p;
      run_pulse <= run_wrap && !clear_p;
      // an adjust wrap on the way out of ADJUST is dropped
      sec_pulse <= adj_wrap && !clear_p && adj_d && sel_d;
      min_pulse <= adj_wrap && !clear_p && adj_d && !sel_d;

      if (clear_p || state == S_IDLE) begin
        rcnt <= '0;
      end else if (state == S_RUN) begin
        rcnt <= run_wrap ? '0 : rcnt + 1'b1;
      end

      if (clear_p || state != S_ADJ) begin
        acnt <= '0;
      end else begin
        acnt <= adj_wrap ? '0 : acnt + 1'b1;
      end
    end
  end

  assign bus.mode     = state;
  assign bus.run_tick = run_pulse;
  assign bus.inc_sec  = sec_pulse;
  assign bus.inc_min  = min_pulse;
  assign bus.cnt_clr  = clr_pulse;
  assign bus.blink_on = (state != S_ADJ) || (acnt < ADJ_HALF);

endmodule
